sipo_frame_rx: RTL and testbench
================================

# sipo_frame_rx

Framed serial receiver that sits at the far end of the team's serial shift-register chain. It samples the serial line once per clock, detects a start bit, shifts in `WIDTH` data bits LSB-first and checks the stop bit. It then presents the word on a parallel output under a valid/ready handshake. Malformed frames and overruns are flagged.

## Interface
- `WIDTH`, default 8: data bits per frame; legal range 2–32.
- `clk`  input  1: rising-edge clock; one serial bit per cycle.
- `clear`  input  1: reset, synchronous and active-high.
- `si`  input  1: serial line; idles at 0.
- `data_out`  output  WIDTH: last accepted word; reset value 0.
- `valid`  output  1: `data_out` holds an unconsumed word; reset value 0.
- `ready`  input  1: consumer accepts `data_out` at a clock edge where `valid && ready`.
- `busy`  output  1: a frame is in progress (state is not IDLE); reset value 0.
- `frame_err`  output  1: one-cycle pulse, stop bit was not 0; reset value 0.
- `overrun`  output  1: one-cycle pulse, completed word dropped because `valid && !ready`; reset value 0.

## Operation
- Frame format: start bit (1), then `WIDTH` data bits LSB first, then optional parity bit (see Configuration), then stop bit (0).
- States:
  - IDLE: `si==1` goes to DATA, bit counter = 0; otherwise stay in IDLE.
  - DATA: shift `si` into `shreg[WIDTH-1]`, shift right, counter+1. Counter reaching `WIDTH-1` goes to PARITY if enabled, else STOP.
  - PARITY: sample the parity bit, then go to STOP.
  - STOP: sample the stop bit, then go to IDLE.
- Stop sample = 0 and no error:
  - If `valid==0`, or `valid && ready` in the same cycle: load `data_out = shreg`, set `valid = 1`.
  - Otherwise keep the old word, drop the new one, and pulse `overrun` for 1 cycle.
- Stop sample = 1: pulse `frame_err`, discard the word, go to IDLE. The next frame may start one cycle later.
- Handshake:
  - `valid && ready` with no load in that cycle: `valid` goes 0 next cycle.
  - Load and consume in the same cycle: `valid` stays 1 with the new word.
  - `data_out` is stable while `valid && !ready`.
- Back-to-back frames: after STOP the FSM is in IDLE. A start bit on the very next cycle is accepted, so there are no gap cycles.
- `clear` has priority over everything, including mid-frame. It returns to IDLE, clears `shreg`, the counter, `data_out` and all flags. A partial frame is lost.
- `si` is sampled directly. Synchronisation is the driver's responsibility.

## Timing
- Start bit sampled at edge k. Data bits are sampled at edges k+1 … k+WIDTH. Stop bit is sampled at edge k+WIDTH+1, or k+WIDTH+2 with parity.
- `valid` and `data_out` update on the stop-sample edge. `frame_err` and `overrun` are high for exactly the cycle following that edge.
- Frame period is WIDTH+2 cycles, or WIDTH+3 with parity. Maximum throughput is one word per frame period.
- `ready` may be held high permanently.

## Configuration
- Macro `SIPO_RX_PARITY_EN`.
- Defined:
  - Adds the PARITY state and one even-parity bit after the data.
  - Adds output `parity_err` (1 bit, reset value 0). It pulses with the stop-sample edge when the XOR of data and parity bits is 1.
  - A frame with a parity error is discarded (no `valid` and no `overrun`). If `frame_err` also applies, both pulse.
- Undefined: no PARITY state, no `parity_err` port, frame is WIDTH+2 bits.

## Structure
- Package `sipo_rx_pkg`:
  - `state_t` enum: IDLE, DATA, PARITY, STOP.
  - Constants `START_BIT = 1'b1`, `STOP_BIT = 1'b0`, `IDLE_LEVEL = 1'b0`.
  - Counter width function `$clog2(WIDTH)`.
- One sub-module, `sipo_shift`: WIDTH-bit serial-in parallel-out register with `clk`, `clear`, `en`, `si`, `q`, shifting right. The FSM, handshake and flags live in the top module.

## Test plan
- Reset: hold `clear` 2 cycles with `si=1` → all outputs 0, FSM stays IDLE; then release.
- Single frame, WIDTH=8, `ready=1`: `si` = 1, 1,0,1,0,0,1,0,1, 0 → `data_out=0xA5`, `valid=1` one cycle after the stop edge, `valid=0` the cycle after.
- Back-to-back 0x3C then 0xC3, `ready=1`, no gap → two valid words in order, no errors.
- Overrun: `ready=0`, send 0x11 then 0x22 → `data_out` stays 0x11, `overrun` pulses 1 cycle; raise `ready` → 0x11 consumed, `valid=0`.
- Framing error: 0x5A with stop bit 1 → `frame_err` pulses, `valid` stays 0; the next good frame 0x0F is received correctly.
- Mid-frame `clear` after 4 data bits, then full frame 0xFF → only 0xFF is delivered. With `SIPO_RX_PARITY_EN`, a wrong parity on 0x01 → `parity_err` pulses and no word is delivered.

Source files
------------

// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg: shared states, line levels and counter sizing for the framed serial receiver
package sipo_rx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/sipo_shift.sv
// sipo_shift: serial-in parallel-out register, new bits enter at the MSB and shift right
module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             si,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (clear) q <= '0;
    else if (en) q <= {si, q[WIDTH-1:1]};
  end
endmodule

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: framed LSB-first serial receiver with valid/ready output, framing and overrun flags
// optional even parity bit and parity_err output when SIPO_RX_PARITY_EN is defined
module sipo_frame_rx
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             si,
  input  logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
`ifdef SIPO_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);
  localparam int CW = cnt_w(WIDTH);
`ifdef SIPO_RX_PARITY_EN
  localparam state_t POST_DATA = PARITY;
`else
  localparam state_t POST_DATA = STOP;
`endif
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic shift_en, last, stop_edge, par_bad, good, load;
  sipo_shift #(.WIDTH(WIDTH)) u_shift (
    .clk(clk),
    .clear(clear),
    .en(shift_en),
    .si(si),
    .q(shreg)
  );
  assign last = cnt == CW'(WIDTH - 1);
  assign stop_edge = state == STOP;
  assign good = stop_edge && si == STOP_BIT && !par_bad;
  assign load = good && (!valid || ready);
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    shift_en = state == DATA;
    next = state == IDLE   ? (si == START_BIT ? DATA : IDLE) :
           state == DATA   ? (last ? POST_DATA : DATA) :
           state == PARITY ? STOP : IDLE;
  end
`ifdef SIPO_RX_PARITY_EN
  logic par_bit;
  assign par_bad = ^shreg ^ par_bit;
  always_ff @(posedge clk) begin
    if (clear) begin
      par_bit <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY) par_bit <= si;
      parity_err <= stop_edge && par_bad;
    end
  end
`else
  assign par_bad = 1'b0;
`endif
  // a word completing while the previous one is still held and not being taken is dropped
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
      data_out <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cnt <= state == DATA ? cnt + CW'(1) : '0;
      if (load) data_out <= shreg;
      valid <= load || (valid && !ready);
      frame_err <= stop_edge && si != STOP_BIT;
      overrun <= good && valid && !ready;
    end
  end
endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb_sipo_frame_rx: directed frames with hand-computed words and flag expectations
module tb_sipo_frame_rx;
  logic clk = 1'b0, clear = 1'b1, si = 1'b0, ready = 1'b0;
  logic [7:0] data_out;
  logic valid, busy, frame_err, overrun;
  int total = 0, bad = 0;
`ifdef SIPO_RX_PARITY_EN
  logic parity_err;
`endif
  sipo_frame_rx #(.WIDTH(8)) dut (
    .clk(clk),
    .clear(clear),
    .si(si),
    .ready(ready),
    .data_out(data_out),
    .valid(valid),
    .busy(busy),
    .frame_err(frame_err),
    .overrun(overrun)
`ifdef SIPO_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic b);
    si = b;
    @(posedge clk);
    #1;
  endtask
  // start bit, data LSB first, optional parity (perr flips it), then the given stop level
  task automatic send(input logic [7:0] w, input logic stop, input logic perr);
    tick(1'b1);
    for (int i = 0; i < 8; i++) tick(w[i]);
`ifdef SIPO_RX_PARITY_EN
    tick(^w ^ perr);
`endif
    tick(stop);
  endtask
  initial begin
    logic [7:0] w;
    si = 1'b1;
    tick(1'b1);
    tick(1'b1);
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    si = 1'b0;
    clear = 1'b0;
    ready = 1'b1;
    tick(1'b0);
    chk("idle_busy", busy, 0);
    tick(1'b1);
    chk("start_busy", busy, 1);
    w = 8'hA5;
    for (int i = 0; i < 8; i++) tick(w[i]);
`ifdef SIPO_RX_PARITY_EN
    tick(^w);
`endif
    tick(1'b0);
    chk("a5_valid", valid, 1);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_ferr", frame_err, 0);
    tick(1'b0);
    chk("a5_consumed", valid, 0);
    send(8'h3C, 1'b0, 1'b0);
    chk("b2b1_valid", valid, 1);
    chk("b2b1_data", data_out, 8'h3C);
    send(8'hC3, 1'b0, 1'b0);
    chk("b2b2_valid", valid, 1);
    chk("b2b2_data", data_out, 8'hC3);
    chk("b2b2_ovr", overrun, 0);
    tick(1'b0);
    ready = 1'b0;
    send(8'h11, 1'b0, 1'b0);
    chk("ovr1_data", data_out, 8'h11);
    send(8'h22, 1'b0, 1'b0);
    chk("ovr2_data", data_out, 8'h11);
    chk("ovr2_pulse", overrun, 1);
    chk("ovr2_valid", valid, 1);
    tick(1'b0);
    chk("ovr_pulse_end", overrun, 0);
    chk("ovr_hold", data_out, 8'h11);
    ready = 1'b1;
    tick(1'b0);
    chk("ovr_consumed", valid, 0);
    send(8'h5A, 1'b1, 1'b0);
    chk("ferr_pulse", frame_err, 1);
    chk("ferr_valid", valid, 0);
    tick(1'b0);
    chk("ferr_end", frame_err, 0);
    send(8'h0F, 1'b0, 1'b0);
    chk("after_ferr_valid", valid, 1);
    chk("after_ferr_data", data_out, 8'h0F);
    tick(1'b0);
    tick(1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1);
    clear = 1'b1;
    tick(1'b1);
    chk("mid_clr_busy", busy, 0);
    chk("mid_clr_data", data_out, 0);
    clear = 1'b0;
    si = 1'b0;
    tick(1'b0);
    send(8'hFF, 1'b0, 1'b0);
    chk("ff_valid", valid, 1);
    chk("ff_data", data_out, 8'hFF);
    tick(1'b0);
    ready = 1'b0;
    send(8'h81, 1'b0, 1'b0);
    w = 8'h42;
    tick(1'b1);
    for (int i = 0; i < 8; i++) tick(w[i]);
`ifdef SIPO_RX_PARITY_EN
    tick(^w);
`endif
    ready = 1'b1;
    tick(1'b0);
    chk("swap_valid", valid, 1);
    chk("swap_data", data_out, 8'h42);
    chk("swap_ovr", overrun, 0);
    tick(1'b0);
    chk("swap_consumed", valid, 0);
`ifdef SIPO_RX_PARITY_EN
    send(8'h01, 1'b0, 1'b1);
    chk("perr_pulse", parity_err, 1);
    chk("perr_valid", valid, 0);
    tick(1'b0);
    chk("perr_end", parity_err, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
